// File: rtl/cfg_capture.sv
// Captures HPS ioctl download bytes into per-bank shadow arrays and commits
// every dirty bank to the active configuration together when apply_en allows.
module cfg_capture #(
   parameter int unsigned        NBANK    = 2,
   parameter int unsigned        DEPTH    = 8,
   parameter logic [NBANK*8-1:0] BANK_IDX = {8'd1, 8'd254}
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     ioctl_download,
   input  logic [7:0]               ioctl_index,
   input  logic                     ioctl_wr,
   input  logic [24:0]              ioctl_addr,
   input  logic [7:0]               ioctl_dout,
   input  logic                     apply_en,
   output logic [NBANK*DEPTH*8-1:0] cfg_data,
   output logic [NBANK-1:0]         cfg_loaded,
   output logic [NBANK-1:0]         cfg_update,
   output logic                     busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BW = (NBANK > 1) ? $clog2(NBANK) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, PEND, COMMIT} state_t;

   state_t           state_q;
   state_t           state_d;
   logic [7:0]       shadow [NBANK][DEPTH];
   logic [7:0]       active [NBANK][DEPTH];
   logic [NBANK-1:0] dirty;
   logic             match_any;
   logic [BW-1:0]    match_bank;
   logic             addr_ok;
   logic             wr_en;
   logic [AW-1:0]    waddr;

   // Index decode; scanning downward lets the lowest matching bank win.
   always_comb begin
      match_any  = 1'b0;
      match_bank = '0;
      for (int b = NBANK - 1; b >= 0; b--) begin
         if (ioctl_index == BANK_IDX[8*b +: 8]) begin
            match_any  = 1'b1;
            match_bank = BW'(b);
         end
      end
   end

   assign addr_ok = (ioctl_addr < 25'(DEPTH));
   assign waddr   = ioctl_addr[AW-1:0];
   assign wr_en   = ioctl_download & ioctl_wr & match_any & addr_ok;

   // State register; busy is registered from the next state so it tracks state_q.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ioctl_download && match_any) state_d = LOAD;
         LOAD:    if (!ioctl_download) state_d = (|dirty) ? PEND : IDLE;
         PEND: begin
            if (ioctl_download && match_any) state_d = LOAD;
            else if (apply_en)               state_d = COMMIT;
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shadow capture and commit; a write landing on the commit edge re-marks its bank dirty.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < NBANK; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
               shadow[b][a] <= 8'h00;
               active[b][a] <= 8'h00;
            end
         end
         dirty      <= '0;
         cfg_loaded <= '0;
         cfg_update <= '0;
      end else begin
         cfg_update <= '0;
         if (state_q == COMMIT) begin
            for (int b = 0; b < NBANK; b++) begin
               if (dirty[b]) begin
                  for (int a = 0; a < DEPTH; a++) active[b][a] <= shadow[b][a];
                  cfg_loaded[b] <= 1'b1;
                  cfg_update[b] <= 1'b1;
               end
            end
            dirty <= '0;
         end
         if (wr_en) begin
            shadow[match_bank][waddr] <= ioctl_dout;
            dirty[match_bank]         <= 1'b1;
         end
      end
   end

   for (genvar gb = 0; gb < NBANK; gb++) begin : g_bank
      for (genvar ga = 0; ga < DEPTH; ga++) begin : g_byte
         assign cfg_data[(gb*DEPTH+ga)*8 +: 8] = active[gb][ga];
      end
   end

endmodule

// File: tb/tb_cfg_capture.sv
// Randomized and directed checks of cfg_capture against a transaction-level
// model of shadow/active banks and commit timing.
module tb_cfg_capture;

   localparam int unsigned NBANK = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned DW    = NBANK * DEPTH * 8;
   localparam int PH_IDLE   = 0;
   localparam int PH_LOAD   = 1;
   localparam int PH_PEND   = 2;
   localparam int PH_COMMIT = 3;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              apply_en;
   logic [DW-1:0]     cfg_data;
   logic [NBANK-1:0]  cfg_loaded;
   logic [NBANK-1:0]  cfg_update;
   logic              busy;

   cfg_capture #(.NBANK(NBANK), .DEPTH(DEPTH), .BANK_IDX({8'd1, 8'd254})) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .apply_en       (apply_en),
      .cfg_data       (cfg_data),
      .cfg_loaded     (cfg_loaded),
      .cfg_update     (cfg_update),
      .busy           (busy)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;
   bit upd_seen;

   // Reference model state
   logic [7:0]       idx_tab  [NBANK] = '{8'd254, 8'd1};
   logic [7:0]       m_shadow [NBANK][DEPTH];
   logic [7:0]       m_active [NBANK][DEPTH];
   logic [NBANK-1:0] m_dirty;
   logic [NBANK-1:0] m_loaded;
   logic [NBANK-1:0] m_update;
   int               m_phase;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int bank_of(input logic [7:0] idx);
      for (int b = 0; b < NBANK; b++) if (idx == idx_tab[b]) return b;
      return -1;
   endfunction

   function automatic logic [DW-1:0] exp_data();
      logic [DW-1:0] v;
      v = '0;
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < DEPTH; a++) v[(b*DEPTH+a)*8 +: 8] = m_active[b][a];
      return v;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < DEPTH; a++) begin
            m_shadow[b][a] = 8'h00;
            m_active[b][a] = 8'h00;
         end
      m_dirty  = '0;
      m_loaded = '0;
      m_update = '0;
      m_phase  = PH_IDLE;
   endtask

   task automatic model_step();
      int m;
      int nxt;
      m   = bank_of(ioctl_index);
      nxt = m_phase;
      case (m_phase)
         PH_IDLE: if (ioctl_download && m >= 0) nxt = PH_LOAD;
         PH_LOAD: if (!ioctl_download) nxt = (m_dirty != 0) ? PH_PEND : PH_IDLE;
         PH_PEND: begin
            if (ioctl_download && m >= 0) nxt = PH_LOAD;
            else if (apply_en)            nxt = PH_COMMIT;
         end
         default: nxt = PH_IDLE;
      endcase
      m_update = '0;
      if (m_phase == PH_COMMIT) begin
         for (int b = 0; b < NBANK; b++)
            if (m_dirty[b]) begin
               for (int a = 0; a < DEPTH; a++) m_active[b][a] = m_shadow[b][a];
               m_loaded[b] = 1'b1;
               m_update[b] = 1'b1;
            end
         m_dirty = '0;
      end
      if (ioctl_download && ioctl_wr && m >= 0 && ioctl_addr < DEPTH) begin
         m_shadow[m][ioctl_addr] = ioctl_dout;
         m_dirty[m] = 1'b1;
      end
      m_phase = nxt;
   endtask

   task automatic compare_all();
      check("cfg_data",   256'(cfg_data),   256'(exp_data()));
      check("cfg_loaded", 256'(cfg_loaded), 256'(m_loaded));
      check("cfg_update", 256'(cfg_update), 256'(m_update));
      check("busy",       256'(busy),       256'(m_phase != PH_IDLE));
   endtask

   task automatic tick();
      @(posedge clk_sys);
      if (reset) model_reset();
      else       model_step();
      #1;
      if (cfg_update != 0) upd_seen = 1'b1;
      compare_all();
   endtask

   task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
      ioctl_download = 1'b1;
      ioctl_index    = idx;
      ioctl_wr       = 1'b1;
      ioctl_addr     = addr;
      ioctl_dout     = data;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic idle_for(input logic apply, input int n);
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      apply_en       = apply;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = 8'h00; apply_en = 1'b0;
      model_reset();
      tick(); tick();
      check("reset_data", 256'(cfg_data), 256'(0));
      check("reset_busy", 256'(busy), 256'(0));
      reset = 1'b0;
      tick();

      // Full bank0 load with apply held high
      apply_en = 1'b1;
      for (int a = 0; a < 8; a++) wr_byte(8'd254, 25'(a), 8'(8'h11 + a));
      idle_for(1'b1, 3);
      check("bank0_full", 256'(cfg_data[63:0]), 256'(64'h1817161514131211));
      check("upd_b0", 256'(cfg_update), 256'(2'b01));
      check("loaded_b0", 256'(cfg_loaded), 256'(2'b01));
      tick();
      check("upd_pulse_end", 256'(cfg_update), 256'(2'b00));

      // Commit held off by apply_en low
      apply_en = 1'b0;
      wr_byte(8'd1, 25'd0, 8'hA5);
      idle_for(1'b0, 100);
      check("pend_busy", 256'(busy), 256'(1));
      check("pend_hold", 256'(cfg_data[71:64]), 256'(8'h00));
      idle_for(1'b1, 2);
      check("bank1_a5", 256'(cfg_data[71:64]), 256'(8'hA5));

      // Rejected writes: out of range and unmatched index
      tick();
      upd_seen = 1'b0;
      wr_byte(8'd254, 25'h8, 8'hFF);
      wr_byte(8'd254, 25'h100, 8'hEE);
      wr_byte(8'd0, 25'h0, 8'h77);
      idle_for(1'b1, 6);
      check("reject_busy", 256'(busy), 256'(0));
      check("reject_no_upd", 256'(upd_seen), 256'(0));
      check("reject_data", 256'(cfg_data), 256'({64'h00000000000000A5, 64'h1817161514131211}));

      // Second bank joins a pending commit
      wr_byte(8'd254, 25'd7, 8'h99);
      idle_for(1'b0, 3);
      wr_byte(8'd1, 25'd1, 8'h3C);
      idle_for(1'b1, 3);
      check("both_upd", 256'(cfg_update), 256'(2'b11));
      check("both_b1", 256'(cfg_data[79:72]), 256'(8'h3C));

      // Partial reload merges with prior bank0 contents
      tick();
      wr_byte(8'd254, 25'd7, 8'h18);
      wr_byte(8'd254, 25'd2, 8'h00);
      wr_byte(8'd254, 25'd2, 8'h55);
      idle_for(1'b1, 4);
      check("merge_b0", 256'(cfg_data[63:0]), 256'(64'h1817161514551211));

      // Async reset in the middle of a load
      for (int a = 0; a < 3; a++) wr_byte(8'd254, 25'(a), 8'hC0);
      reset = 1'b1;
      #1;
      model_reset();
      check("arst_data", 256'(cfg_data), 256'(0));
      check("arst_loaded", 256'(cfg_loaded), 256'(0));
      check("arst_busy", 256'(busy), 256'(0));
      tick(); tick();
      ioctl_download = 1'b0;
      reset = 1'b0;
      idle_for(1'b1, 20);
      check("arst_no_commit", 256'(cfg_loaded), 256'(0));

      // Randomized download sessions
      for (int t = 0; t < 60; t++) begin
         logic [7:0] idx;
         case ($urandom_range(0, 3))
            0: idx = 8'd254;
            1: idx = 8'd1;
            2: idx = 8'd0;
            default: idx = 8'($urandom);
         endcase
         ioctl_index = idx;
         for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
            ioctl_download = 1'b1;
            ioctl_wr   = 1'($urandom);
            ioctl_addr = ($urandom_range(0, 9) < 8) ? 25'($urandom_range(0, 7)) : 25'($urandom);
            ioctl_dout = 8'($urandom);
            apply_en   = 1'($urandom);
            tick();
         end
         ioctl_wr = 1'b0;
         for (int i = 0; i < int'($urandom_range(0, 6)); i++) begin
            ioctl_download = 1'b0;
            apply_en = 1'($urandom);
            tick();
         end
      end
      idle_for(1'b1, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
